// File: rtl/viola_defs.sv
// Op encodings shared by the decoder, load/store buffer and memory controller,
// plus helpers that classify load/store ops by access width and direction.
package viola_defs;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_LB   = 5'b10010;
  localparam logic [4:0] OP_LH   = 5'b10011;
  localparam logic [4:0] OP_LW   = 5'b10100;
  localparam logic [4:0] OP_LBU  = 5'b10101;
  localparam logic [4:0] OP_LHU  = 5'b10110;
  localparam logic [4:0] OP_SB   = 5'b10111;
  localparam logic [4:0] OP_SH   = 5'b11000;
  localparam logic [4:0] OP_SW   = 5'b11001;
  localparam logic [4:0] OP_NONE = 5'b11111;

  function automatic logic op_is_load(input logic [4:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [4:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [2:0] op_bytes(input logic [4:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_controller_if.sv
// Request/response ports of the memory controller and its byte-wide RAM bus.
interface memory_controller_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_ins;
  logic [31:0] if_pc_out;
  logic        ls_req;
  logic [4:0]  ls_op;
  logic [31:0] ls_addr;
  logic [31:0] ls_data;
  logic [2:0]  ls_rob;
  logic        ls_done;
  logic [31:0] ls_value;
  logic [2:0]  ls_rob_out;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_op, ls_addr, ls_data, ls_rob, mem_din,
    output if_done, if_ins, if_pc_out, ls_done, ls_value, ls_rob_out,
           mem_dout, mem_a, mem_wr, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_op, ls_addr, ls_data, ls_rob, mem_din,
    input  if_done, if_ins, if_pc_out, ls_done, ls_value, ls_rob_out,
           mem_dout, mem_a, mem_wr, busy
  );
endinterface

// File: rtl/memory_controller_load_extend.sv
// Sign/zero extension of an assembled little-endian load word by load op.
module load_extend
  import viola_defs::*;
(
  input  logic [4:0]  i_op,
  input  logic [31:0] i_raw,
  output logic [31:0] o_ext
);
  always_comb begin
    case (i_op)
      OP_LB:   o_ext = {{24{i_raw[7]}}, i_raw[7:0]};
      OP_LBU:  o_ext = {24'd0, i_raw[7:0]};
      OP_LH:   o_ext = {{16{i_raw[15]}}, i_raw[15:0]};
      OP_LHU:  o_ext = {16'd0, i_raw[15:0]};
      default: o_ext = i_raw;
    endcase
  end
endmodule

// File: rtl/memory_controller.sv
// Round-robin arbiter between fetch and load/store ports driving a byte-wide RAM,
// one byte per cycle, returning assembled words and store completions.
module memory_controller
  import viola_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  memory_controller_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_e;
  typedef enum logic {P_FETCH, P_LS} port_e;

  state_e      r_state, s_nx;
  port_e       r_last, last_nx, r_port, port_nx;
  logic [31:0] r_addr, addr_nx, r_buf, buf_nx, r_data, data_nx;
  logic [2:0]  r_n, n_nx, r_rob, rob_nx;
  logic [1:0]  r_k, k_nx;
  logic [4:0]  r_op, op_nx;
  logic [31:0] r_mem_a, mema_nx;
  logic [7:0]  r_mem_dout, dout_nx;
  logic        r_mem_wr, wr_nx;
  logic        r_if_done, ifd_nx, r_ls_done, lsd_nx;
  logic [31:0] r_if_ins, ins_nx, r_if_pc, pc_nx, r_ls_value, val_nx;
  logic [2:0]  r_ls_rob, lrob_nx;

  logic        w_if_ok, w_ls_ok, w_gnt_ls, w_last;
  logic [1:0]  w_k1;
  logic [31:0] w_raw, w_ext, w_next_a;

  // A port whose done is high this cycle is still holding the request it just finished.
  assign w_if_ok  = bus.if_req && !r_if_done;
  assign w_ls_ok  = bus.ls_req && !r_ls_done &&
                    (op_is_load(bus.ls_op) || op_is_store(bus.ls_op));
  assign w_gnt_ls = w_ls_ok && (!w_if_ok || (r_last == P_FETCH));
  assign w_last   = ((3'(r_k) + 3'd1) == r_n);
  assign w_k1     = r_k + 2'd1;
  assign w_next_a = r_addr + {30'd0, r_k} + 32'd1;

  always_comb begin
    w_raw = r_buf;
    w_raw[{r_k, 3'b000} +: 8] = bus.mem_din;
  end

  load_extend u_ext (.i_op(r_op), .i_raw(w_raw), .o_ext(w_ext));

  always_comb begin
    s_nx = r_state; last_nx = r_last; port_nx = r_port; addr_nx = r_addr;
    n_nx = r_n; k_nx = r_k; buf_nx = r_buf; op_nx = r_op; rob_nx = r_rob;
    data_nx = r_data; mema_nx = r_mem_a; dout_nx = r_mem_dout; wr_nx = r_mem_wr;
    ifd_nx = 1'b0; ins_nx = r_if_ins; pc_nx = r_if_pc;
    lsd_nx = 1'b0; val_nx = r_ls_value; lrob_nx = r_ls_rob;
    unique case (r_state)
      S_IDLE: begin
        if (w_if_ok || w_ls_ok) begin
          k_nx   = 2'd0;
          buf_nx = 32'd0;
          if (w_gnt_ls) begin
            port_nx = P_LS;    last_nx = P_LS;
            addr_nx = bus.ls_addr; mema_nx = bus.ls_addr;
            op_nx   = bus.ls_op;   n_nx = op_bytes(bus.ls_op);
            rob_nx  = bus.ls_rob;  data_nx = bus.ls_data;
            if (op_is_store(bus.ls_op)) begin
              s_nx    = S_WRITE;
              wr_nx   = 1'b1;
              dout_nx = bus.ls_data[7:0];
            end else begin
              s_nx = S_READ;
            end
          end else begin
            port_nx = P_FETCH; last_nx = P_FETCH;
            addr_nx = bus.if_addr; mema_nx = bus.if_addr;
            op_nx   = OP_LW;       n_nx = 3'd4;
            s_nx    = S_READ;
          end
        end
      end
      S_READ: begin
        buf_nx = w_raw;
        if (w_last) begin
          s_nx = S_IDLE;
          if (r_port == P_FETCH) begin
            ifd_nx = 1'b1; ins_nx = w_raw; pc_nx = r_addr;
          end else begin
            lsd_nx = 1'b1; val_nx = w_ext; lrob_nx = r_rob;
          end
        end else begin
          k_nx = w_k1; mema_nx = w_next_a;
        end
      end
      S_WRITE: begin
        if (w_last) begin
          s_nx = S_IDLE; wr_nx = 1'b0;
          lsd_nx = 1'b1; val_nx = 32'd0; lrob_nx = r_rob;
        end else begin
          k_nx = w_k1; mema_nx = w_next_a;
          dout_nx = r_data[{w_k1, 3'b000} +: 8];
        end
      end
      default: s_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE; r_last <= P_FETCH; r_port <= P_FETCH;
      r_addr <= '0; r_n <= '0; r_k <= '0; r_buf <= '0; r_op <= OP_NONE;
      r_rob <= '0; r_data <= '0; r_mem_a <= '0; r_mem_dout <= '0; r_mem_wr <= 1'b0;
      r_if_done <= 1'b0; r_if_ins <= '0; r_if_pc <= '0;
      r_ls_done <= 1'b0; r_ls_value <= '0; r_ls_rob <= '0;
    end else begin
      r_state <= s_nx; r_last <= last_nx; r_port <= port_nx;
      r_addr <= addr_nx; r_n <= n_nx; r_k <= k_nx; r_buf <= buf_nx; r_op <= op_nx;
      r_rob <= rob_nx; r_data <= data_nx; r_mem_a <= mema_nx; r_mem_dout <= dout_nx;
      r_mem_wr <= wr_nx;
      r_if_done <= ifd_nx; r_if_ins <= ins_nx; r_if_pc <= pc_nx;
      r_ls_done <= lsd_nx; r_ls_value <= val_nx; r_ls_rob <= lrob_nx;
    end
  end

  assign bus.if_done    = r_if_done;
  assign bus.if_ins     = r_if_ins;
  assign bus.if_pc_out  = r_if_pc;
  assign bus.ls_done    = r_ls_done;
  assign bus.ls_value   = r_ls_value;
  assign bus.ls_rob_out = r_ls_rob;
  assign bus.mem_a      = r_mem_a;
  assign bus.mem_dout   = r_mem_dout;
  assign bus.mem_wr     = r_mem_wr;
  assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_memory_controller.sv
// Directed and randomized bench for memory_controller with a byte-array reference model.
module tb_memory_controller;
  import viola_defs::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_controller_if bus();
  memory_controller dut (.clk(clk), .rst(rst), .bus(bus));

  // RAM environment: 4 KiB aliased on the low 12 address bits, combinational read.
  logic [7:0]  ram [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_a  = '0;
  logic [7:0]  pre_d  = '0;
  int          wcnt = 0, rcnt = 0;
  logic [31:0] wlog_a [0:255];
  logic [7:0]  wlog_d [0:255];
  logic [31:0] rlog_a [0:255];

  assign bus.mem_din = ram[bus.mem_a[11:0]];

  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (bus.mem_wr) begin
      ram[bus.mem_a[11:0]] <= bus.mem_dout;
      wlog_a[wcnt[7:0]] <= bus.mem_a;
      wlog_d[wcnt[7:0]] <= bus.mem_dout;
      wcnt <= wcnt + 1;
    end
    if (bus.busy && !bus.mem_wr) begin
      rlog_a[rcnt[7:0]] <= bus.mem_a;
      rcnt <= rcnt + 1;
    end
  end

  logic [7:0] mref [0:4095];
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [4:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [31:0] addr);
    logic [31:0] v = 0;
    for (int i = 0; i < nbytes(op); i++)
      v = v + (32'(mref[12'(addr + 32'(i))]) << (8 * i));
    if (op == OP_LB && v >= 32'd128)   v = v - 32'd256;
    if (op == OP_LH && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  task automatic ref_store(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] data);
    for (int i = 0; i < nbytes(op); i++)
      mref[12'(addr + 32'(i))] = 8'(data >> (8 * i));
  endtask

  task automatic ls_txn(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] rob, output logic [31:0] val, output logic [2:0] rtag,
                        output int cyc, output int wrc);
    bit seen = 0;
    cyc = 0; wrc = 0; val = 'x; rtag = 'x;
    @(negedge clk);
    bus.ls_req = 1'b1; bus.ls_op = op; bus.ls_addr = addr; bus.ls_data = data; bus.ls_rob = rob;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (bus.mem_wr) wrc++;
      if (bus.ls_done) begin
        seen = 1; val = bus.ls_value; rtag = bus.ls_rob_out;
        bus.ls_req = 1'b0;
      end
    end
    bus.ls_req = 1'b0;
    chk("ls_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic fetch_txn(input logic [31:0] addr, output logic [31:0] ins,
                           output logic [31:0] pc, output int cyc);
    bit seen = 0;
    cyc = 0; ins = 'x; pc = 'x;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = addr;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (bus.if_done) begin
        seen = 1; ins = bus.if_ins; pc = bus.if_pc_out;
        bus.if_req = 1'b0;
      end
    end
    bus.if_req = 1'b0;
    chk("if_done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    logic [31:0] v, pc, a, d;
    logic [2:0]  rt, rb;
    logic [4:0]  op;
    logic [4:0]  ops [0:7];
    int cyc, wrc, w0, r0, nev, bad, cnt;
    logic [2:0] order;

    ops[0] = OP_LB; ops[1] = OP_LH; ops[2] = OP_LW; ops[3] = OP_LBU;
    ops[4] = OP_LHU; ops[5] = OP_SB; ops[6] = OP_SH; ops[7] = OP_SW;
    bus.if_req = 0; bus.if_addr = 0; bus.ls_req = 0; bus.ls_op = OP_NONE;
    bus.ls_addr = 0; bus.ls_data = 0; bus.ls_rob = 0;

    for (int i = 0; i < 4096; i++) mref[i] = 8'($urandom);
    mref[12'h100] = 8'h13; mref[12'h101] = 8'h05; mref[12'h102] = 8'hA0; mref[12'h103] = 8'h00;
    mref[12'h400] = 8'h80;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk); pre_we = 1'b1; pre_a = 12'(i); pre_d = mref[i];
    end
    @(negedge clk); pre_we = 1'b0;

    chk("rst_mem_a", bus.mem_a, 0);        chk("rst_mem_dout", 32'(bus.mem_dout), 0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 0); chk("rst_if_done", 32'(bus.if_done), 0);
    chk("rst_if_ins", bus.if_ins, 0);      chk("rst_if_pc", bus.if_pc_out, 0);
    chk("rst_ls_done", 32'(bus.ls_done), 0); chk("rst_ls_value", bus.ls_value, 0);
    chk("rst_ls_rob", 32'(bus.ls_rob_out), 0); chk("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;

    fetch_txn(32'h100, v, pc, cyc);
    chk("fetch_ins", v, 32'h00A00513); chk("fetch_pc", pc, 32'h100); chk("fetch_lat", cyc, 5);

    // Both ports held: LS wins first conflict, then fetch, then LS again.
    @(negedge clk);
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.ls_req = 1; bus.ls_op = OP_LB; bus.ls_addr = 32'h400; bus.ls_rob = 3'd5;
    nev = 0; order = 0;
    for (int t = 0; t < 40 && nev < 3; t++) begin
      @(negedge clk);
      if (bus.ls_done) begin
        order = {order[1:0], 1'b1}; nev++;
        chk("both_ls_val", bus.ls_value, ref_load(OP_LB, 32'h400));
        chk("both_ls_rob", 32'(bus.ls_rob_out), 5);
      end
      if (bus.if_done) begin
        order = {order[1:0], 1'b0}; nev++;
        chk("both_if_ins", bus.if_ins, 32'h00A00513);
      end
    end
    bus.if_req = 0; bus.ls_req = 0;
    chk("both_count", nev, 3); chk("both_order", 32'(order), 32'b101);

    ls_txn(OP_LB, 32'h400, 0, 3'd3, v, rt, cyc, wrc);
    chk("lb_val", v, 32'hFFFFFF80); chk("lb_rob", 32'(rt), 3); chk("lb_lat", cyc, 2);
    ls_txn(OP_LBU, 32'h400, 0, 3'd6, v, rt, cyc, wrc);
    chk("lbu_val", v, 32'h00000080); chk("lbu_rob", 32'(rt), 6);

    w0 = wcnt;
    ls_txn(OP_SW, 32'h200, 32'hDEADBEEF, 3'd1, v, rt, cyc, wrc);
    ref_store(OP_SW, 32'h200, 32'hDEADBEEF);
    chk("sw_val", v, 0); chk("sw_wr_cycles", wrc, 4); chk("sw_lat", cyc, 5);
    chk("sw_nwrites", wcnt - w0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("sw_byte", 32'(wlog_d[8'(w0 + i)]), (32'hDEADBEEF >> (8 * i)) & 32'hFF);
      chk("sw_addr", wlog_a[8'(w0 + i)], 32'h200 + 32'(i));
    end
    ls_txn(OP_LW, 32'h200, 0, 3'd2, v, rt, cyc, wrc);
    chk("lw_val", v, 32'hDEADBEEF);

    r0 = rcnt;
    ls_txn(OP_LW, 32'hFFFFFFFE, 0, 3'd4, v, rt, cyc, wrc);
    chk("wrap_val", v, ref_load(OP_LW, 32'hFFFFFFFE));
    chk("wrap_a0", rlog_a[8'(r0)], 32'hFFFFFFFE); chk("wrap_a1", rlog_a[8'(r0 + 1)], 32'hFFFFFFFF);
    chk("wrap_a2", rlog_a[8'(r0 + 2)], 32'h0);    chk("wrap_a3", rlog_a[8'(r0 + 3)], 32'h1);

    // Op outside the load/store set is ignored.
    @(negedge clk); bus.ls_req = 1; bus.ls_op = OP_NONE; bus.ls_addr = 32'h10;
    cnt = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk); cnt += int'(bus.ls_done) + int'(bus.busy);
    end
    bus.ls_op = OP_ADD;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); cnt += int'(bus.ls_done) + int'(bus.busy);
    end
    bus.ls_req = 0;
    chk("ignored_op", cnt, 0);

    for (int it = 0; it < 40; it++) begin
      a = $urandom; d = $urandom; rb = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        fetch_txn(a, v, pc, cyc);
        chk("rnd_if_ins", v, ref_load(OP_LW, a)); chk("rnd_if_pc", pc, a);
        chk("rnd_if_lat", cyc, 5);
      end else begin
        op = ops[$urandom_range(0, 7)];
        ls_txn(op, a, d, rb, v, rt, cyc, wrc);
        if (op_is_store(op)) begin
          ref_store(op, a, d);
          chk("rnd_st_val", v, 0); chk("rnd_st_wr", wrc, nbytes(op));
        end else begin
          chk("rnd_ld_val", v, ref_load(op, a));
        end
        chk("rnd_rob", 32'(rt), 32'(rb)); chk("rnd_lat", cyc, nbytes(op) + 1);
      end
    end

    // Reset during the third byte of a store.
    @(negedge clk);
    bus.ls_req = 1; bus.ls_op = OP_SW; bus.ls_addr = 32'h300; bus.ls_data = 32'h11223344; bus.ls_rob = 3'd7;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_wr", 32'(bus.mem_wr), 0); chk("rst_mid_busy", 32'(bus.busy), 0);
    ref_store(OP_SH, 32'h300, 32'h00003344);
    bus.ls_req = 0;
    cnt = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); cnt += int'(bus.ls_done);
    end
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); cnt += int'(bus.ls_done);
    end
    chk("rst_mid_nodone", cnt, 0);
    chk("rst_mid_b2", 32'(ram[12'h302]), 32'(mref[12'h302]));
    ls_txn(OP_LB, 32'h300, 0, 3'd2, v, rt, cyc, wrc);
    chk("post_rst_lb", v, 32'h00000044); chk("post_rst_rob", 32'(rt), 2);

    bad = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== mref[i]) bad++;
    chk("ram_image", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
